relu_maxpool2x2: RTL and testbench

RELU_MAXPOOL2X2 -- requirements
Module: relu_maxpool2x2

---
 rtl/relu_maxpool2x2_pkg.sv | 19 +
 rtl/relu_maxpool2x2_max4_relu.sv | 24 ++
 rtl/relu_maxpool2x2.sv | 133 +++++++++++++
 tb/tb_relu_maxpool2x2.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/relu_maxpool2x2_pkg.sv
// Shared definitions for the conv3x3 -> relu_maxpool2x2 pipeline:
// sample format, pooling FSM encoding and a dimension clamp helper.
package relu_maxpool2x2_pkg;

    localparam int TOTAL_BITS = 16;
    localparam int FRAC_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } pool_state_t;

    function automatic logic [3:0] clamp_dim(input logic [3:0] dim, input int max_dim);
        return (int'(dim) > max_dim) ? 4'(max_dim) : dim;
    endfunction

endpackage

// File: rtl/relu_maxpool2x2_max4_relu.sv
// Combinational signed maximum of four words, floored at zero (ReLU folded
// into the 2x2 max, since max(relu(x)) == relu(max(x))).
module max4_relu #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] y_o
);

    logic signed [W-1:0] m_ab;
    logic signed [W-1:0] m_cd;
    logic signed [W-1:0] m_all;

    always_comb begin
        m_ab  = ($signed(a_i) > $signed(b_i)) ? $signed(a_i) : $signed(b_i);
        m_cd  = ($signed(c_i) > $signed(d_i)) ? $signed(c_i) : $signed(d_i);
        m_all = (m_ab > m_cd) ? m_ab : m_cd;
        y_o   = m_all[W-1] ? '0 : m_all;
    end

endmodule

// File: rtl/relu_maxpool2x2.sv
// ReLU + 2x2 max-pool over a captured conv3x3 output frame; one pooled word
// is written per RUN cycle in row-major window order.
module relu_maxpool2x2
    import relu_maxpool2x2_pkg::*;
#(
    parameter int total_bits  = TOTAL_BITS,
    parameter int frac_bits   = FRAC_BITS,
    parameter int max_in_rows = 6,
    parameter int max_in_cols = 6
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [3:0]                                            in_rows,
    input  logic [3:0]                                            in_cols,
    input  logic [max_in_rows*max_in_cols*total_bits-1:0]         in_matrix,
    output logic [(max_in_rows/2)*(max_in_cols/2)*total_bits-1:0] pooled_matrix,
    output logic [3:0]                                            out_rows,
    output logic [3:0]                                            out_cols,
    output logic                                                  busy,
    output logic                                                  done
);

    localparam int IN_WORDS  = max_in_rows * max_in_cols;
    localparam int OUT_WORDS = (max_in_rows / 2) * (max_in_cols / 2);
    localparam int AW        = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int OW        = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    // The fractional split is carried for downstream consumers only.
    if (frac_bits >= total_bits) begin : g_bad_format
        $error("frac_bits must be smaller than total_bits");
    end

    pool_state_t           state_q, state_d;
    logic [total_bits-1:0] mat_q  [IN_WORDS];
    logic [total_bits-1:0] pool_q [OUT_WORDS];
    logic [3:0]            rows_q, cols_q;
    logic [3:0]            out_rows_q, out_cols_q;
    logic [3:0]            i_q, j_q;
    logic [OW-1:0]         idx_q;

    logic [7:0]            base;
    logic [AW-1:0]         addr_a, addr_b, addr_c, addr_d;
    logic [total_bits-1:0] win_max;
    logic                  last_win;

    // Top-left word of window (i,j) sits at (2i)*cols + 2j in the captured frame.
    always_comb begin
        base   = 8'({i_q, 1'b0}) * 8'(cols_q) + 8'({j_q, 1'b0});
        addr_a = AW'(base);
        addr_b = AW'(base + 8'd1);
        addr_c = AW'(base + 8'(cols_q));
        addr_d = AW'(base + 8'(cols_q) + 8'd1);
    end

    max4_relu #(
        .W(total_bits)
    ) u_max4_relu (
        .a_i(mat_q[addr_a]),
        .b_i(mat_q[addr_b]),
        .c_i(mat_q[addr_c]),
        .d_i(mat_q[addr_d]),
        .y_o(win_max)
    );

    assign last_win = (i_q == out_rows_q - 4'd1) && (j_q == out_cols_q - 4'd1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
            ST_LOAD:          state_d = (rows_q >= 4'd2 && cols_q >= 4'd2) ? ST_RUN : ST_DONE;
            ST_RUN:           if (last_win) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            out_rows_q <= '0;
            out_cols_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            idx_q      <= '0;
            for (int k = 0; k < IN_WORDS; k++) mat_q[k] <= '0;
            for (int k = 0; k < OUT_WORDS; k++) pool_q[k] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        rows_q <= clamp_dim(in_rows, max_in_rows);
                        cols_q <= clamp_dim(in_cols, max_in_cols);
                        for (int k = 0; k < IN_WORDS; k++)
                            mat_q[k] <= in_matrix[k*total_bits +: total_bits];
                    end
                end
                ST_LOAD: begin
                    out_rows_q <= rows_q >> 1;
                    out_cols_q <= cols_q >> 1;
                    i_q        <= '0;
                    j_q        <= '0;
                    idx_q      <= '0;
                    for (int k = 0; k < OUT_WORDS; k++) pool_q[k] <= '0;
                end
                ST_RUN: begin
                    pool_q[idx_q] <= win_max;
                    idx_q         <= idx_q + OW'(1);
                    if (j_q == out_cols_q - 4'd1) begin
                        j_q <= '0;
                        i_q <= i_q + 4'd1;
                    end else begin
                        j_q <= j_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < OUT_WORDS; g++) begin : g_pack
        assign pooled_matrix[g*total_bits +: total_bits] = pool_q[g];
    end

    assign out_rows = out_rows_q;
    assign out_cols = out_cols_q;
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Bench for relu_maxpool2x2: directed vector table, mid-run corner sequences
// and randomized frames checked against a plain-arithmetic pooling model.
module tb_relu_maxpool2x2;

    localparam int IW = 6 * 6 * 16;
    localparam int OWB = 3 * 3 * 16;

    logic           clk;
    logic           rst;
    logic           start;
    logic [3:0]     in_rows;
    logic [3:0]     in_cols;
    logic [IW-1:0]  in_matrix;
    logic [OWB-1:0] pooled_matrix;
    logic [3:0]     out_rows;
    logic [3:0]     out_cols;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    relu_maxpool2x2 dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_rows(in_rows),
        .in_cols(in_cols),
        .in_matrix(in_matrix),
        .pooled_matrix(pooled_matrix),
        .out_rows(out_rows),
        .out_cols(out_cols),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [IW-1:0]  m;
        logic [3:0]     r;
        logic [3:0]     c;
        logic [OWB-1:0] epm;
        logic [3:0]     er;
        logic [3:0]     ec;
        int             edge_n;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string nm, input logic [OWB-1:0] act, input logic [OWB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input logic [3:0] d);
        return (int'(d) > 6) ? 6 : int'(d);
    endfunction

    // Pooling reference: every 2x2 window of the frame, best value starting from zero.
    function automatic logic [OWB-1:0] model_pool(input logic [IW-1:0] m, input logic [3:0] r, input logic [3:0] c);
        int rr, cc;
        logic [OWB-1:0] res;
        logic signed [15:0] w, best;
        rr  = clampi(r);
        cc  = clampi(c);
        res = '0;
        for (int i = 0; i < rr / 2; i++) begin
            for (int j = 0; j < cc / 2; j++) begin
                best = '0;
                for (int di = 0; di < 2; di++) begin
                    for (int dj = 0; dj < 2; dj++) begin
                        w = m[((2*i+di)*cc + 2*j+dj)*16 +: 16];
                        if (w > best) best = w;
                    end
                end
                res[(i*(cc/2)+j)*16 +: 16] = best;
            end
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] rand_frame();
        logic [IW-1:0] m;
        for (int k = 0; k < 36; k++) m[k*16 +: 16] = 16'($urandom);
        return m;
    endfunction

    task automatic run_and_check(input string nm, input logic [IW-1:0] m, input logic [3:0] r,
                                 input logic [3:0] c, input logic [OWB-1:0] epm,
                                 input logic [3:0] er, input logic [3:0] ec, input int edge_n);
        int   edges;
        logic ctrl_ok;
        in_matrix = m;
        in_rows   = r;
        in_cols   = c;
        start     = 1'b1;
        step();
        start   = 1'b0;
        edges   = 1;
        ctrl_ok = 1'b1;
        while (done !== 1'b1 && edges < 64) begin
            if (busy !== 1'b1) ctrl_ok = 1'b0;
            step();
            edges++;
        end
        check({nm, " done_edge"}, OWB'(edges), OWB'(edge_n));
        check({nm, " busy_while_working"}, OWB'(ctrl_ok), OWB'(1));
        check({nm, " busy_at_done"}, OWB'(busy), OWB'(0));
        check({nm, " pooled"}, pooled_matrix, epm);
        check({nm, " out_rows"}, OWB'(out_rows), OWB'(er));
        check({nm, " out_cols"}, OWB'(out_cols), OWB'(ec));
    endtask

    initial begin
        logic [IW-1:0]  m, mb;
        logic [OWB-1:0] e;
        logic [3:0]     r, c;
        int             edges, n;

        // Directed table
        m = '0; e = '0;
        m[15:0] = 16'h0054; m[31:16] = 16'h0038; m[47:32] = 16'hFF00; m[63:48] = 16'h0070;
        e[15:0] = 16'h0070;
        vecs[0] = '{m: m, r: 4'd2, c: 4'd2, epm: e, er: 4'd1, ec: 4'd1, edge_n: 3};

        m = '0; e = '0;
        m[15:0] = 16'hFF00; m[31:16] = 16'hFE00; m[47:32] = 16'h8000; m[63:48] = 16'hFFFF;
        vecs[1] = '{m: m, r: 4'd2, c: 4'd2, epm: e, er: 4'd1, ec: 4'd1, edge_n: 3};

        m = '0; e = '0;
        for (int rr = 0; rr < 6; rr++)
            for (int cc = 0; cc < 6; cc++)
                m[(rr*6+cc)*16 +: 16] = ((rr + cc) % 2 == 1) ? 16'h0100 : 16'h0000;
        for (int k = 0; k < 9; k++) e[k*16 +: 16] = 16'h0100;
        vecs[2] = '{m: m, r: 4'd6, c: 4'd6, epm: e, er: 4'd3, ec: 4'd3, edge_n: 11};

        m = '0; e = '0;
        for (int rr = 0; rr < 5; rr++)
            for (int cc = 0; cc < 5; cc++)
                m[(rr*5+cc)*16 +: 16] = 16'((rr*5 + cc) * 256);
        e[15:0] = 16'h0600; e[31:16] = 16'h0800; e[47:32] = 16'h1000; e[63:48] = 16'h1200;
        vecs[3] = '{m: m, r: 4'd5, c: 4'd5, epm: e, er: 4'd2, ec: 4'd2, edge_n: 6};

        // Reset state
        rst = 1'b1; start = 1'b0; in_rows = '0; in_cols = '0; in_matrix = '0;
        step();
        step();
        check("reset pooled", pooled_matrix, '0);
        check("reset dims", OWB'({out_rows, out_cols}), '0);
        check("reset busy_done", OWB'({busy, done}), '0);
        rst = 1'b0;
        step();
        step();
        check("idle without start", OWB'({busy, done}), '0);

        foreach (vecs[v])
            run_and_check($sformatf("vec%0d", v), vecs[v].m, vecs[v].r, vecs[v].c,
                          vecs[v].epm, vecs[v].er, vecs[v].ec, vecs[v].edge_n);

        // DONE holds with start low
        step();
        step();
        check("done holds", OWB'({busy, done}), OWB'(2'b01));

        // start re-pulsed and inputs changed mid-run
        m = rand_frame();
        mb = rand_frame();
        in_matrix = m; in_rows = 4'd6; in_cols = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        in_matrix = mb; in_rows = 4'd2; in_cols = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        edges = 4;
        while (done !== 1'b1 && edges < 64) begin
            step();
            edges++;
        end
        check("midrun done_edge", OWB'(edges), OWB'(11));
        check("midrun pooled", pooled_matrix, model_pool(m, 4'd6, 4'd6));
        check("midrun dims", OWB'({out_rows, out_cols}), OWB'({4'd3, 4'd3}));

        // Reset asserted in the third RUN cycle
        in_matrix = vecs[2].m; in_rows = 4'd6; in_cols = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("pre-abort pooled nonzero", OWB'(pooled_matrix != '0), OWB'(1));
        #2 rst = 1'b1;
        #1;
        check("abort pooled", pooled_matrix, '0);
        check("abort dims", OWB'({out_rows, out_cols}), '0);
        check("abort busy_done", OWB'({busy, done}), '0);
        step();
        rst = 1'b0;
        step();
        check("after abort idle", OWB'({busy, done}), '0);
        run_and_check("post-abort", vecs[0].m, vecs[0].r, vecs[0].c,
                      vecs[0].epm, vecs[0].er, vecs[0].ec, vecs[0].edge_n);

        // Oversized dimensions clamp to the maximum frame
        m = rand_frame();
        run_and_check("clamp", m, 4'd15, 4'd9, model_pool(m, 4'd15, 4'd9), 4'd3, 4'd3, 11);

        // Randomized frames, including odd and degenerate sizes
        for (int t = 0; t < 24; t++) begin
            m = rand_frame();
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 6));
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 6));
            n = (clampi(r) / 2) * (clampi(c) / 2);
            run_and_check($sformatf("rand%0d", t), m, r, c, model_pool(m, r, c),
                          4'(clampi(r) / 2), 4'(clampi(c) / 2), n + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
